// File: rtl/nxn_game_controller.sv
// nxn_game_controller: N x N board, K-in-a-row game FSM that owns the board, the turn,
// the win/draw flags and saturating per-player scores.
module nxn_game_controller #(
  parameter int N       = 3,
  parameter int K       = 3,
  parameter int SCORE_W = 4
) (
  input  logic               clk_100MHz,
  input  logic               rst,
  input  logic [N*N-1:0]     cell_click,
  input  logic               new_round,
  input  logic               clear_score,
  output logic [N*N-1:0]     board_x,
  output logic [N*N-1:0]     board_o,
  output logic               turn_x,
  output logic               win_x,
  output logic               win_o,
  output logic               draw,
  output logic [SCORE_W-1:0] score_x,
  output logic [SCORE_W-1:0] score_o,
  output logic [1:0]         state
);
  localparam int C  = N * N;
  localparam int IW = $clog2(C);

  typedef enum logic [1:0] {READY = 2'd0, CHECK = 2'd1, RELEASE = 2'd2, OVER = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [C-1:0]         bx_q, bx_d, bo_q, bo_d;
  logic                 turn_q, turn_d, start_q, start_d;
  logic                 wx_q, wx_d, wo_q, wo_d, dr_q, dr_d;
  logic [SCORE_W-1:0]   sx_q, sx_d, so_q, so_d;
  logic [IW-1:0]        sel;
  logic [C-1:0]         mine;
  logic                 line;

  // Off-board coordinates read as empty so every run can be scanned without bounds flags.
  function automatic logic at(input logic [C-1:0] b, input int r, input int c);
    int i;
    i = (r < N && c >= 0 && c < N) ? r * N + c : 0;
    return (r < N && c >= 0 && c < N) && b[i];
  endfunction

  function automatic logic has_line(input logic [C-1:0] b);
    logic w, h, v, d, a;
    w = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        h = 1'b1;
        v = 1'b1;
        d = 1'b1;
        a = 1'b1;
        for (int k = 0; k < K; k++) begin
          h &= at(b, r, c + k);
          v &= at(b, r + k, c);
          d &= at(b, r + k, c + k);
          a &= at(b, r + k, c - k);
        end
        w |= h | v | d | a;
      end
    return w;
  endfunction

  always_comb begin
    sel = '0;
    for (int i = C - 1; i >= 0; i--)
      if (cell_click[i]) sel = IW'(i);
  end

  assign mine = turn_q ? bx_q : bo_q;
  assign line = has_line(mine);

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    bo_d    = bo_q;
    turn_d  = turn_q;
    start_d = start_q;
    wx_d    = wx_q;
    wo_d    = wo_q;
    dr_d    = dr_q;
    sx_d    = sx_q;
    so_d    = so_q;
    unique case (state_q)
      READY:
        if (|cell_click) begin
          if (bx_q[sel] | bo_q[sel]) state_d = RELEASE;
          else begin
            bx_d[sel] = bx_q[sel] | turn_q;
            bo_d[sel] = bo_q[sel] | ~turn_q;
            state_d   = CHECK;
          end
        end
      CHECK:
        if (line) begin
          wx_d    = turn_q;
          wo_d    = ~turn_q;
          sx_d    = sx_q + SCORE_W'(turn_q && sx_q != '1);
          so_d    = so_q + SCORE_W'(!turn_q && so_q != '1);
          state_d = OVER;
        end else if (&(bx_q | bo_q)) begin
          dr_d    = 1'b1;
          state_d = OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = RELEASE;
        end
      RELEASE: state_d = |cell_click ? RELEASE : READY;
      OVER:
        if (new_round) begin
          bx_d    = '0;
          bo_d    = '0;
          wx_d    = 1'b0;
          wo_d    = 1'b0;
          dr_d    = 1'b0;
          start_d = ~start_q;
          turn_d  = ~start_q;
          state_d = RELEASE;
        end
      default: state_d = RELEASE;
    endcase
    if (clear_score) begin
      state_d = RELEASE;
      bx_d    = '0;
      bo_d    = '0;
      turn_d  = 1'b1;
      start_d = 1'b1;
      wx_d    = 1'b0;
      wo_d    = 1'b0;
      dr_d    = 1'b0;
      sx_d    = '0;
      so_d    = '0;
    end
  end

  always_ff @(posedge clk_100MHz)
    if (rst) begin
      state_q <= RELEASE;
      bx_q    <= '0;
      bo_q    <= '0;
      turn_q  <= 1'b1;
      start_q <= 1'b1;
      wx_q    <= 1'b0;
      wo_q    <= 1'b0;
      dr_q    <= 1'b0;
      sx_q    <= '0;
      so_q    <= '0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      bo_q    <= bo_d;
      turn_q  <= turn_d;
      start_q <= start_d;
      wx_q    <= wx_d;
      wo_q    <= wo_d;
      dr_q    <= dr_d;
      sx_q    <= sx_d;
      so_q    <= so_d;
    end

  assign board_x = bx_q;
  assign board_o = bo_q;
  assign turn_x  = turn_q;
  assign win_x   = wx_q;
  assign win_o   = wo_q;
  assign draw    = dr_q;
  assign score_x = sx_q;
  assign score_o = so_q;
  assign state   = state_q;
endmodule

// File: tb/tb_nxn_game_controller.sv
// tb_nxn_game_controller: scoreboard bench; a behavioural game model queues expected outputs
// as stimulus is driven, and they are popped and compared once the DUT has had time to respond.
module tb_nxn_game_controller;
  logic        clk, rst, nr, clr;
  logic [8:0]  click, bx, bo;
  logic        t, wx, wo, dr;
  logic [3:0]  sx, so;
  logic [1:0]  st;
  logic [24:0] click5, bx5, bo5;
  logic        t5, wx5, wo5, dr5;
  logic [3:0]  sx5, so5;
  logic [1:0]  st5;
  int          checks = 0, errors = 0;

  typedef struct {
    logic [8:0] bx, bo;
    logic       t, wx, wo, dr;
    logic [3:0] sx, so;
    logic [1:0] st;
  } exp_t;
  exp_t q[$];

  logic [8:0] m_bx, m_bo;
  logic       m_t, m_start, m_wx, m_wo, m_dr;
  logic [3:0] m_sx, m_so;
  logic [1:0] m_st;

  nxn_game_controller #(.N(3), .K(3), .SCORE_W(4)) u3 (
    .clk_100MHz(clk), .rst(rst), .cell_click(click), .new_round(nr), .clear_score(clr),
    .board_x(bx), .board_o(bo), .turn_x(t), .win_x(wx), .win_o(wo), .draw(dr),
    .score_x(sx), .score_o(so), .state(st));

  nxn_game_controller #(.N(5), .K(4), .SCORE_W(4)) u5 (
    .clk_100MHz(clk), .rst(rst), .cell_click(click5), .new_round(1'b0), .clear_score(1'b0),
    .board_x(bx5), .board_o(bo5), .turn_x(t5), .win_x(wx5), .win_o(wo5), .draw(dr5),
    .score_x(sx5), .score_o(so5), .state(st5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic m_line(input logic [8:0] b);
    int dr_v[4] = '{0, 1, 1, 1};
    int dc_v[4] = '{1, 0, 1, -1};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int d = 0; d < 4; d++) begin
          int n = 0;
          for (int k = 0; k < 3; k++) begin
            int rr = r + k * dr_v[d];
            int cl = c + k * dc_v[d];
            if (rr >= 0 && rr < 3 && cl >= 0 && cl < 3 && b[rr*3+cl]) n++;
          end
          if (n == 3) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_bx = '0; m_bo = '0; m_t = 1'b1; m_start = 1'b1;
    m_wx = 1'b0; m_wo = 1'b0; m_dr = 1'b0; m_sx = '0; m_so = '0; m_st = 2'd2;
  endtask

  // Model of one sampled click followed by the CHECK cycle.
  task automatic m_click(input logic [8:0] m);
    int c = -1;
    if (m_st != 2'd0 || m == 0) return;
    for (int i = 8; i >= 0; i--) if (m[i]) c = i;
    if (m_bx[c] || m_bo[c]) begin
      m_st = 2'd2;
      return;
    end
    if (m_t) m_bx[c] = 1'b1; else m_bo[c] = 1'b1;
    if (m_line(m_t ? m_bx : m_bo)) begin
      if (m_t) begin m_wx = 1'b1; if (m_sx != 15) m_sx++; end
      else begin m_wo = 1'b1; if (m_so != 15) m_so++; end
      m_st = 2'd3;
    end else if ((m_bx | m_bo) == 9'h1ff) begin
      m_dr = 1'b1;
      m_st = 2'd3;
    end else begin
      m_t = ~m_t;
      m_st = 2'd2;
    end
  endtask

  task automatic push();
    exp_t e;
    e.bx = m_bx; e.bo = m_bo; e.t = m_t; e.wx = m_wx; e.wo = m_wo; e.dr = m_dr;
    e.sx = m_sx; e.so = m_so; e.st = m_st;
    q.push_back(e);
  endtask

  task automatic cmp(input string tag);
    exp_t e = q.pop_front();
    check({tag, ".board_x"}, 32'(bx), 32'(e.bx));
    check({tag, ".board_o"}, 32'(bo), 32'(e.bo));
    check({tag, ".turn_x"}, 32'(t), 32'(e.t));
    check({tag, ".win_x"}, 32'(wx), 32'(e.wx));
    check({tag, ".win_o"}, 32'(wo), 32'(e.wo));
    check({tag, ".draw"}, 32'(dr), 32'(e.dr));
    check({tag, ".score_x"}, 32'(sx), 32'(e.sx));
    check({tag, ".score_o"}, 32'(so), 32'(e.so));
    check({tag, ".state"}, 32'(st), 32'(e.st));
  endtask

  task automatic rel(input string tag);
    @(negedge clk);
    click = '0;
    if (m_st == 2'd2) m_st = 2'd0;
    push();
    repeat (2) @(posedge clk);
    #1 cmp({tag, ".rel"});
  endtask

  task automatic press(input logic [8:0] m, input string tag);
    @(negedge clk);
    click = m;
    m_click(m);
    push();
    repeat (2) @(posedge clk);
    #1 cmp(tag);
    push();
    @(posedge clk);
    #1 cmp({tag, ".hold"});
    rel(tag);
  endtask

  task automatic play(input int s[9], input int n, input string tag);
    logic [8:0] m;
    for (int i = 0; i < n; i++) begin
      m = '0;
      m[s[i]] = 1'b1;
      press(m, $sformatf("%s.m%0d", tag, i));
    end
  endtask

  task automatic new_rnd(input string tag);
    @(negedge clk);
    nr = 1'b1;
    if (m_st == 2'd3) begin
      m_bx = '0; m_bo = '0; m_wx = 1'b0; m_wo = 1'b0; m_dr = 1'b0;
      m_t = ~m_start; m_start = ~m_start; m_st = 2'd2;
    end
    push();
    @(posedge clk);
    #1 cmp(tag);
    if (m_st == 2'd2) m_st = 2'd0;
    push();
    repeat (3) @(posedge clk);
    #1 cmp({tag, ".held"});
    nr = 1'b0;
  endtask

  // Clicks a free cell, then hits clear_score or rst while the FSM sits in CHECK.
  task automatic abort(input int idx, input logic use_rst, input string tag);
    @(negedge clk);
    click = '0;
    click[idx] = 1'b1;
    @(posedge clk);
    #1 check({tag, ".in_check"}, 32'(st), 32'd1);
    if (use_rst) rst = 1'b1; else clr = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clr = 1'b0;
    m_reset();
    push();
    cmp(tag);
    rel(tag);
  endtask

  task automatic press5(input int idx);
    @(negedge clk);
    click5 = '0;
    click5[idx] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    click5 = '0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; nr = 1'b0; clr = 1'b0; click = '0; click5 = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 push();
    cmp("reset");
    @(negedge clk);
    rst = 1'b0;
    rel("start");
    play('{0, 3, 1, 4, 2, 0, 0, 0, 0}, 5, "xwin");
    check("xwin.board_x_lit", 32'(bx), 32'h007);
    new_rnd("nr1");
    press(9'h010, "occ.first");
    press(9'h010, "occ.again");
    abort(0, 1'b0, "clear");
    play('{0, 1, 2, 4, 3, 5, 7, 6, 8}, 9, "draw");
    check("draw.flag_lit", 32'(dr), 32'd1);
    new_rnd("nr2");
    check("nr2.o_starts", 32'(t), 32'd0);
    abort(4, 1'b1, "rst_mid");
    play('{0, 3, 1, 4, 8, 5, 0, 0, 0}, 6, "owin");
    new_rnd("nr3");
    for (int r = 0; r < 16; r++) begin
      if (m_start) play('{0, 3, 1, 4, 2, 0, 0, 0, 0}, 5, $sformatf("sat%0d", r));
      else play('{3, 0, 4, 1, 8, 2, 0, 0, 0}, 6, $sformatf("sat%0d", r));
      check($sformatf("sat%0d.win", r), 32'(wx), 32'd1);
      new_rnd($sformatf("sat%0d.nr", r));
    end
    check("sat.score_x", 32'(sx), 32'd15);
    press(9'h024, "multi.low");
    press(9'h024, "multi.occ");
    press5(1); press5(0); press5(7); press5(5); press5(13); press5(10);
    #1 check("n5.no_win_yet", 32'(wx5), 32'd0);
    press5(19);
    #1 check("n5.win_x", 32'(wx5), 32'd1);
    check("n5.state", 32'(st5), 32'd3);
    check("n5.score_x", 32'(sx5), 32'd1);
    check("n5.board_x", 32'(bx5), 32'h0082082);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
